// File: rtl/flipdot_dot_sequencer.sv
// flipdot_dot_sequencer: scans a flip-dot panel dot by dot, firing each dot's set/clear coil for a tick-timed pulse
module flipdot_dot_sequencer #(
  parameter int COLS        = 28,
  parameter int ROWS        = 7,
  parameter int COL_W       = 5,
  parameter int ROW_W       = 3,
  parameter int PULSE_TICKS = 3,
  parameter int GAP_TICKS   = 1,
  parameter int TW          = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tick,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             frame_done,
  output logic [COL_W-1:0] rd_col,
  output logic [ROW_W-1:0] rd_row,
  input  logic             rd_data,
  output logic [COL_W-1:0] col_sel,
  output logic [ROW_W-1:0] row_sel,
  output logic             coil_set,
  output logic             coil_clr
);
  typedef enum logic [2:0] {IDLE, FETCH, LATCH, WAITP, PULSE, GAP, NEXT, DONE} state_t;
  state_t        state, nxt;
  logic [TW-1:0] cnt;
  logic          pix;
  logic          last_col, last_dot, counting, cnt_hit, kill;
  logic          busy_d, done_d, set_d, clr_d;
  assign last_col = rd_col == COL_W'(COLS - 1);
  assign last_dot = last_col && rd_row == ROW_W'(ROWS - 1);
  assign counting = state == PULSE || state == GAP;
  assign cnt_hit  = tick && (cnt + TW'(1)) == ((state == PULSE) ? TW'(PULSE_TICKS) : TW'(GAP_TICKS));
  assign kill     = abort && state != IDLE;
  // state register
  always_ff @(posedge clk)
    if (!reset_n) state <= IDLE;
    else          state <= nxt;
  // next-state: abort from any active state returns straight to IDLE
  always_comb begin
    nxt = state;
    if (kill) nxt = IDLE;
    else
      case (state)
        IDLE:    nxt = (start && !abort) ? FETCH : IDLE;
        FETCH:   nxt = LATCH;
        LATCH:   nxt = WAITP;
        WAITP:   nxt = tick ? PULSE : WAITP;
        PULSE:   nxt = cnt_hit ? ((GAP_TICKS == 0) ? NEXT : GAP) : PULSE;
        GAP:     nxt = cnt_hit ? NEXT : GAP;
        NEXT:    nxt = last_dot ? DONE : FETCH;
        DONE:    nxt = IDLE;
        default: nxt = IDLE;
      endcase
  end
  // output decode from the upcoming state so the registered outputs line up with it
  always_comb begin
    busy_d = nxt != IDLE && nxt != DONE;
    done_d = nxt == DONE;
    set_d  = nxt == PULSE && pix;
    clr_d  = nxt == PULSE && !pix;
  end
  // registered outputs, tick counter, pixel latch and scan addresses
  always_ff @(posedge clk)
    if (!reset_n) begin
      busy       <= 1'b0;
      frame_done <= 1'b0;
      coil_set   <= 1'b0;
      coil_clr   <= 1'b0;
      cnt        <= '0;
      pix        <= 1'b0;
      rd_col     <= '0;
      rd_row     <= '0;
      col_sel    <= '0;
      row_sel    <= '0;
    end else begin
      busy       <= busy_d;
      frame_done <= done_d;
      coil_set   <= set_d;
      coil_clr   <= clr_d;
      cnt        <= (counting && nxt == state) ? cnt + TW'(tick) : '0;
      if (kill || state == IDLE) begin
        rd_col  <= '0;
        rd_row  <= '0;
        col_sel <= kill ? '0 : col_sel;
        row_sel <= kill ? '0 : row_sel;
      end else if (state == LATCH) begin
        pix     <= rd_data;
        col_sel <= rd_col;
        row_sel <= rd_row;
      end else if (state == NEXT) begin
        rd_col <= last_col ? '0 : rd_col + COL_W'(1);
        rd_row <= last_dot ? '0 : (last_col ? rd_row + ROW_W'(1) : rd_row);
      end
    end
endmodule
